// File: rtl/slot_alloc_pkg.sv
// ---------------------------------------------------------------------------
// slot_alloc_pkg
//   Shared definitions for the slot allocator: slot count, index/count widths,
//   the matching typedefs and a one-hot decode helper.
// ---------------------------------------------------------------------------
package slot_alloc_pkg;

    localparam int NUM_SLOTS = 32;
    localparam int ID_W      = $clog2(NUM_SLOTS);
    localparam int CNT_W     = ID_W + 1;

    typedef logic [ID_W-1:0]      id_t;
    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [NUM_SLOTS-1:0] vec_t;

    // One-hot mask with only bit `id` set.
    function automatic vec_t onehot(input id_t id);
        vec_t v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/slot_alloc_s.sv
// ---------------------------------------------------------------------------
// s : combinational circular first-zero search
//   Scans x_i starting at pos_i-1 and walking downwards, wrapping from 0 to
//   W-1; pos_i itself is the last position examined.
//   x_i     in  W        vector to search (1 = occupied)
//   pos_i   in  log2(W)  search origin
//   y_o     out W        one-hot of the first zero found (0 when none)
//   y_enc_o out log2(W)  index of the first zero found (0 when none)
//   any_o   out 1        a zero exists in x_i
// ---------------------------------------------------------------------------
module s #(
    parameter int W = 32
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic [W-1:0]         y_o,
    output logic [$clog2(W)-1:0] y_enc_o,
    output logic                 any_o
);
    localparam int IW = $clog2(W);

    always_comb begin
        y_enc_o = '0;
        any_o   = 1'b0;
        // k = W truncates to 0, so the origin itself is checked last.
        // Index arithmetic wraps for free because W is a power of two.
        for (int k = 1; k <= W; k++) begin
            logic [IW-1:0] idx;
            idx = pos_i - IW'(k);
            if (!any_o && !x_i[idx]) begin
                any_o   = 1'b1;
                y_enc_o = idx;
            end
        end
        y_o = any_o ? (W'(1) << y_enc_o) : '0;
    end

endmodule

// File: rtl/slot_alloc.sv
// ---------------------------------------------------------------------------
// slot_alloc : round-robin slot/tag allocator
//   Tracks slot occupancy, offers the next free slot (descending from the last
//   granted slot, wrapping) as a registered valid/ready grant, and accepts
//   slot releases.
//   clk          in  clock
//   arst_n       in  asynchronous reset, active-low
//   clr_i        in  synchronous clear of occupancy, count and pointer
//   alloc_vld_o  out a free slot is offered
//   alloc_id_o   out index of the offered slot
//   alloc_rdy_i  in  consumer takes the offered slot
//   free_vld_i   in  release request
//   free_id_i    in  slot to release
//   count_o      out number of occupied slots
//   full_o       out all slots occupied
//   empty_o      out no slot occupied
//   err_o        out sticky: a release targeted an unoccupied slot
// W must match NUM_SLOTS in slot_alloc_pkg (onehot() is sized by it).
// ---------------------------------------------------------------------------
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int W = NUM_SLOTS
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clr_i,
    output logic                 alloc_vld_o,
    output logic [$clog2(W)-1:0] alloc_id_o,
    input  logic                 alloc_rdy_i,
    input  logic                 free_vld_i,
    input  logic [$clog2(W)-1:0] free_id_i,
    output logic [$clog2(W):0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);
    localparam int IW = $clog2(W);
    localparam int CW = IW + 1;

    logic [W-1:0]  occ_q, occ_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          cand_vld_q;
    logic [IW-1:0] cand_id_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          hs;
    logic          fr;
    logic          occ_at_free;
    logic [W-1:0]  y_unused;
    logic [IW-1:0] srch_id;
    logic          srch_any;

    assign hs          = cand_vld_q & alloc_rdy_i;
    assign occ_at_free = occ_q[free_id_i];
    assign fr          = free_vld_i & occ_at_free;

    always_comb begin
        occ_d = occ_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        // An illegal free is recorded even in a clear cycle; clear never
        // resets the error flag.
        err_d = err_q | (free_vld_i & ~occ_at_free);
        if (clr_i) begin
            occ_d = '0;
            ptr_d = '0;
            cnt_d = '0;
        end else begin
            if (hs) begin
                occ_d = occ_d | onehot(cand_id_q);
                ptr_d = cand_id_q;
            end
            if (fr) begin
                occ_d = occ_d & ~onehot(free_id_i);
            end
            cnt_d = cnt_q + CW'(hs) - CW'(fr);
        end
    end

    // Search on next-state values so a grant or release is reflected in the
    // offer one cycle later, which sustains one grant per cycle.
    s #(
        .W (W)
    ) u_search (
        .x_i     (occ_d),
        .pos_i   (ptr_d),
        .y_o     (y_unused),
        .y_enc_o (srch_id),
        .any_o   (srch_any)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ_q      <= '0;
            ptr_q      <= '0;
            cand_vld_q <= 1'b0;
            cand_id_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            ptr_q      <= ptr_d;
            cand_vld_q <= srch_any;
            cand_id_q  <= srch_id;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign alloc_vld_o = cand_vld_q;
    assign alloc_id_o  = cand_id_q;
    assign count_o     = cnt_q;
    assign err_o       = err_q;
    assign full_o      = (cnt_q == CW'(W));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: doc/slot_alloc.md
Name: slot_alloc

Overview:
- Round-robin slot/tag allocator built around the combinational circular first-zero search stage `s`.
- Holds a W-bit occupancy vector and a rotating search pointer, and registers the next free slot as a valid/ready grant.
- Accepts slot releases from downstream consumers.
- Sits directly upstream of `s`: it produces `s`'s x_i/pos_i and consumes y_enc_o/any_o.

Parameters:
- W, 32, number of slots. Power of two, W >= 4.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous reset, active-low.
- clr_i  in  1  synchronous clear of all occupancy and the pointer.
- alloc_vld_o  out  1  a free slot is offered.
- alloc_id_o  out  $clog2(W)  index of the offered slot.
- alloc_rdy_i  in  1  consumer accepts the offered slot; handshake = alloc_vld_o & alloc_rdy_i.
- free_vld_i  in  1  release request.
- free_id_i  in  $clog2(W)  slot to release.
- count_o  out  $clog2(W)+1  number of occupied slots.
- full_o  out  1  count_o == W.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky: a free targeted an unoccupied slot.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low (clk, arst_n).
- State registers: occ_r[W], ptr_r[$clog2(W)], cand_vld_r, cand_id_r, cnt_r, err_r.
  - All reset to 0.
  - Consequence: alloc_vld_o=0, count_o=0, empty_o=1, full_o=0, err_o=0 during reset.
- Outputs map directly to registers: alloc_vld_o=cand_vld_r, alloc_id_o=cand_id_r, count_o=cnt_r, err_o=err_r. full_o and empty_o are decoded from cnt_r.
- Search semantics of `s`: given vector x and position p, it returns the first 0 at p-1, p-2, ... descending circularly. any=0 iff x is all ones.
- Per-cycle next state, when clr_i=0:
  - hs = alloc_vld_o & alloc_rdy_i.
  - fr = free_vld_i & occ_r[free_id_i].
  - occ_n = (occ_r | (hs ? onehot(cand_id_r) : 0)) & ~(fr ? onehot(free_id_i) : 0).
  - ptr_n = hs ? cand_id_r : ptr_r.
  - cnt_n = cnt_r + hs - fr.
  - err_n = err_r | (free_vld_i & ~occ_r[free_id_i]).
- Candidate: `s` evaluates x=occ_n, pos=ptr_n. Then cand_vld_r <= any, cand_id_r <= y_enc.
  - Latency: a release becomes offerable one cycle after free_vld_i.
  - After a handshake, the next candidate appears in the following cycle, so back-to-back grants at 1 per cycle are supported.
- Allocation order: descending, wrapping from 0 to W-1. The first grant after reset is W-1.
- alloc_rdy_i while alloc_vld_o=0: ignored, no state change.
- Simultaneous handshake and free:
  - Both apply.
  - free_id_i never equals cand_id_r for a legal free, because cand_id_r is unoccupied. That case is therefore an illegal free: it flags err and the grant still occurs.
- Illegal free (slot not occupied): no change to occ/cnt; err_r set to 1, sticky until reset.
- Full: cand_vld_r=0. A free in the full state makes that slot's index the candidate in the next cycle.
- clr_i=1 has priority over alloc and free:
  - occ_r=0, ptr_r=0, cnt_r=0.
  - The candidate is recomputed from occ=0, pos=0, so W-1 is offered in the next cycle.
  - Any handshake in the clr_i cycle is discarded.
  - err_r is NOT cleared.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
- alloc_vld_o/alloc_id_o must be stable while alloc_vld_o=1 and alloc_rdy_i=0, unless a free or clr_i occurs.
  - Note: a free may alter the candidate only if it reorders the search. Pointer-relative search means a freed slot nearer ptr_r-1 replaces the current offer. Consumers must sample the id only at the handshake.

Decomposition:
- Shared package `slot_alloc_pkg`:
  - localparams for ID_W = $clog2(W) and CNT_W = ID_W+1.
  - typedefs id_t and cnt_t.
  - a onehot(id) function.
- Single sub-module: the existing circular search `s` (its y_o is unused).
- Counter and occupancy update live in slot_alloc itself.

Test Plan:
- Release reset, rdy=0 -> cycle 1: alloc_vld_o=1, alloc_id_o=31, count_o=0, empty_o=1, outputs held stable.
- rdy=1 for 32 cycles -> ids 31,30,...,0 granted one per cycle; then alloc_vld_o=0, full_o=1, count_o=32.
- From full, free_id_i=5 -> next cycle alloc_vld_o=1, id=5, count_o=31; rdy=1 -> full_o=1 again.
- Grant 31,30,29; free 31; continue granting -> 28 down to 0, then wraps to 31; count_o is tracked exactly.
- Empty, free_id_i=3 -> err_o=1 from the next cycle and stays 1; count_o=0, occupancy unchanged; a later clr_i does not clear err_o.
- 10 slots allocated, clr_i pulsed with rdy=1 and free_vld_i=1 -> next cycle count_o=0, empty_o=1, alloc_id_o=31; no grant counted in the clr cycle.
